// File: rtl/control_sequencer.sv
// Micro-program sequencer feeding control_mem: runs the shared fetch routine,
// dispatches on opcode to a per-opcode execute window, and halts on halt or illegal opcode.
module control_sequencer #(
  parameter int ADDR_W     = 4,
  parameter int FETCH_LEN  = 3,
  parameter int EXEC_SLOTS = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step_en,
  input  logic [3:0]        opcode,
  input  logic              micro_end,
  input  logic              micro_halt,
  output logic [ADDR_W-1:0] control_addr,
  output logic              reset_control_word,
  output logic              halted,
  output logic              illegal_op
);

  localparam int STEP_W = (EXEC_SLOTS > 1) ? $clog2(EXEC_SLOTS) : 1;
  localparam logic [ADDR_W-1:0] FETCH_LAST = ADDR_W'(FETCH_LEN - 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(EXEC_SLOTS - 1);

  typedef enum logic [2:0] {FLUSH, FETCH, DISPATCH, EXEC, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt, entry;
  logic [STEP_W-1:0] step, step_nxt;
  logic              ill_nxt, rcw_nxt, halted_nxt;

  // Execute routines are packed back to back right after the fetch routine.
  assign entry = ADDR_W'(FETCH_LEN) + ADDR_W'(opcode[1:0]) * ADDR_W'(EXEC_SLOTS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= FLUSH;
      control_addr       <= '0;
      step               <= '0;
      reset_control_word <= 1'b1;
      halted             <= 1'b0;
      illegal_op         <= 1'b0;
    end else begin
      state              <= state_nxt;
      control_addr       <= addr_nxt;
      step               <= step_nxt;
      reset_control_word <= rcw_nxt;
      halted             <= halted_nxt;
      illegal_op         <= ill_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = control_addr;
    step_nxt  = step;
    ill_nxt   = illegal_op;
    unique case (state)
      FLUSH: begin
        state_nxt = FETCH;
        addr_nxt  = '0;
        step_nxt  = '0;
      end
      FETCH: if (step_en) begin
        if (control_addr == FETCH_LAST) state_nxt = DISPATCH;
        else                            addr_nxt  = control_addr + ADDR_W'(1);
      end
      DISPATCH: if (step_en) begin
        if (opcode[3:2] == 2'b00) begin
          state_nxt = EXEC;
          addr_nxt  = entry;
          step_nxt  = '0;
        end else begin
          state_nxt = HALT;
          addr_nxt  = '0;
          ill_nxt   = 1'b1;
        end
      end
      EXEC: if (step_en) begin
        // halt outranks end; end and an exhausted window both return to fetch
        if (micro_halt) begin
          state_nxt = HALT;
          addr_nxt  = '0;
        end else if (micro_end || step == STEP_LAST) begin
          state_nxt = FETCH;
          addr_nxt  = '0;
          step_nxt  = '0;
        end else begin
          addr_nxt = control_addr + ADDR_W'(1);
          step_nxt = step + STEP_W'(1);
        end
      end
      HALT:    addr_nxt  = '0;
      default: state_nxt = FLUSH;
    endcase
  end

  always_comb begin
    rcw_nxt    = (state_nxt == FLUSH) || (state_nxt == DISPATCH) || (state_nxt == HALT);
    halted_nxt = (state_nxt == HALT);
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected outputs are queued per step
// and popped for comparison once the DUT has produced that cycle's outputs.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       step_en = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       micro_end = 1'b0;
  logic       micro_halt = 1'b0;
  logic [3:0] control_addr;
  logic       reset_control_word, halted, illegal_op;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic       rcw;
    logic       hlt;
    logic       ill;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  val;
  } exp_t;

  exp_t exp_q[$];

  control_sequencer dut (
    .clk(clk), .reset_n(reset_n), .step_en(step_en), .opcode(opcode),
    .micro_end(micro_end), .micro_halt(micro_halt), .control_addr(control_addr),
    .reset_control_word(reset_control_word), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic compare();
    exp_t e;
    obs_t got;
    e   = exp_q.pop_front();
    got = '{control_addr, reset_control_word, halted, illegal_op};
    n_chk++;
    assert (got === e.val) n_pass++;
    else $error("FAIL %s: got addr=%0d rcw=%b halted=%b ill=%b, want addr=%0d rcw=%b halted=%b ill=%b",
                e.tag, got.addr, got.rcw, got.hlt, got.ill, e.val.addr, e.val.rcw, e.val.hlt, e.val.ill);
  endtask

  task automatic push(input string tag, input int a, input bit r, input bit h, input bit i);
    exp_t e;
    e.tag = tag;
    e.val = '{4'(a), r, h, i};
    exp_q.push_back(e);
  endtask

  // Expect outputs right now (no clock edge)
  task automatic now(input string tag, input int a, input bit r, input bit h, input bit i);
    push(tag, a, r, h, i);
    compare();
  endtask

  // Expect outputs after the next rising edge
  task automatic cyc(input string tag, input int a, input bit r, input bit h, input bit i);
    push(tag, a, r, h, i);
    @(posedge clk); #1;
    compare();
  endtask

  task automatic reset_and_fetch(input string tag);
    reset_n = 1'b0; #1;
    now({tag, "_rst"}, 0, 1, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    now({tag, "_flush"}, 0, 1, 0, 0);
    cyc({tag, "_f0"}, 0, 0, 0, 0);
    cyc({tag, "_f1"}, 1, 0, 0, 0);
    cyc({tag, "_f2"}, 2, 0, 0, 0);
    cyc({tag, "_disp"}, 2, 1, 0, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    // 1 + 2: reset, fetch, opcode 2 forced return after three slots
    opcode = 4'b0010;
    reset_and_fetch("t1");
    cyc("t2_e0", 9, 0, 0, 0);
    cyc("t2_e1", 10, 0, 0, 0);
    cyc("t2_e2", 11, 0, 0, 0);
    cyc("t2_ret", 0, 0, 0, 0);

    // 3: micro_end at entry returns to fetch immediately
    opcode = 4'b0001;
    cyc("t3_f1", 1, 0, 0, 0);
    cyc("t3_f2", 2, 0, 0, 0);
    cyc("t3_disp", 2, 1, 0, 0);
    cyc("t3_e0", 6, 0, 0, 0);
    micro_end = 1'b1;
    cyc("t3_end", 0, 0, 0, 0);
    micro_end = 1'b0;

    // 5: stall at fetch addr 1, then halt beats end
    cyc("t5_f1", 1, 0, 0, 0);
    step_en = 1'b0;
    micro_end = 1'b1;
    for (int k = 0; k < 3; k++) cyc("t5_stall", 1, 0, 0, 0);
    micro_end = 1'b0;
    step_en = 1'b1;
    cyc("t5_f2", 2, 0, 0, 0);
    cyc("t5_disp", 2, 1, 0, 0);
    cyc("t5_e0", 6, 0, 0, 0);
    step_en = 1'b0;
    micro_halt = 1'b1;
    cyc("t5_halt_gated", 6, 0, 0, 0);
    step_en = 1'b1;
    micro_end = 1'b1;
    cyc("t5_halt", 0, 1, 1, 0);
    micro_halt = 1'b0;
    micro_end = 1'b0;
    cyc("t5_hold", 0, 1, 1, 0);

    // 4: illegal opcode halts sticky for 20 cycles of random inputs
    opcode = 4'b0100;
    reset_and_fetch("t4");
    cyc("t4_ill", 0, 1, 1, 1);
    for (int k = 0; k < 20; k++) begin
      step_en    = 1'($urandom_range(0, 1));
      micro_end  = 1'($urandom_range(0, 1));
      micro_halt = 1'($urandom_range(0, 1));
      opcode     = 4'($urandom_range(0, 15));
      cyc("t4_hold", 0, 1, 1, 1);
    end
    step_en = 1'b1;
    micro_end = 1'b0;
    micro_halt = 1'b0;

    // 6: asynchronous reset mid-EXEC at addr 10, then the startup sequence repeats
    opcode = 4'b0010;
    reset_and_fetch("t6a");
    cyc("t6_e0", 9, 0, 0, 0);
    cyc("t6_e1", 10, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 now("t6_async", 0, 1, 0, 0);
    @(posedge clk); #1;
    now("t6_held", 0, 1, 0, 0);
    reset_n = 1'b1;
    now("t6_flush", 0, 1, 0, 0);
    cyc("t6_f0", 0, 0, 0, 0);
    cyc("t6_f1", 1, 0, 0, 0);
    cyc("t6_f2", 2, 0, 0, 0);
    cyc("t6_disp", 2, 1, 0, 0);
    cyc("t6_e0b", 9, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
